pb_debounce_array: RTL and testbench

Parametrised push-button front end: synchronises, debounces and decodes `NUM_PB` active-low raw button inputs into clean per-channel events.

- Per-channel edge or level reporting.
- Release pulses.
- Long-press detection.
- Optional auto-repeat while a button is held.

It sits between the board push buttons and the top-level control FSMs, replacing the fixed 4-button controller.

---
 rtl/pb_debounce_array.sv | 176 +++++++++++++++++
 tb/tb_pb_debounce_array.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pb_debounce_array.sv
// pb_debounce_array: synchronises, debounces and decodes active-low push buttons into
// per-channel press / level / release / long-press / auto-repeat events.
//
//   state      | meaning
//   ST_IDLE    | debounced state released, waiting for a debounced press
//   ST_PRESSED | debounced pressed, counting ticks toward the long-press event
//   ST_HELD    | long press reported, counting ticks between auto-repeat pulses
module pb_debounce_array #(
    parameter int NUM_PB       = 4,
    parameter int SAMPLE_DIV   = 50000,
    parameter int DEBOUNCE_LEN = 10,
    parameter int HOLD_TICKS   = 500,
    parameter int REPEAT_TICKS = 100
) (
    input  logic              Clock_50,
    input  logic              Resetn,
    input  logic [NUM_PB-1:0] PB_signal,
    input  logic [NUM_PB-1:0] level_mode,
    input  logic              repeat_en,
    output logic [NUM_PB-1:0] PB_pushed,
    output logic [NUM_PB-1:0] PB_level,
    output logic [NUM_PB-1:0] PB_released,
    output logic [NUM_PB-1:0] PB_long
);

    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam int AGR_W = $clog2(DEBOUNCE_LEN + 1);
    localparam int HLD_W = $clog2(HOLD_TICKS + 1);
    localparam int REP_W = $clog2(REPEAT_TICKS + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [AGR_W-1:0] AGR_LAST = AGR_W'(DEBOUNCE_LEN - 1);
    localparam logic [HLD_W-1:0] HLD_TERM = HLD_W'(HOLD_TICKS);
    localparam logic [REP_W-1:0] REP_TERM = REP_W'(REPEAT_TICKS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } state_t;

    logic [NUM_PB-1:0] sync_1;
    logic [NUM_PB-1:0] sync_2;
    logic [DIV_W-1:0]  div_cnt;
    logic              tick;

    // Inversion happens before the synchroniser so that 1 means pressed internally.
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= ~PB_signal;
            sync_2 <= sync_1;
        end
    end

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    for (genvar i = 0; i < NUM_PB; i++) begin : g_ch
        state_t           state_q, state_d;
        logic             db_q, db_d;
        logic [AGR_W-1:0] agree_q, agree_d;
        logic [HLD_W-1:0] hold_q, hold_d;
        logic [REP_W-1:0] rep_q, rep_d;
        logic             db_rise, db_fall;
        logic             press_ev, rel_ev, long_ev, rep_ev;
        logic             pushed_q, released_q, long_q;

        always_comb begin
            db_d    = db_q;
            agree_d = agree_q;
            if (tick) begin
                if (sync_2[i] == db_q) begin
                    agree_d = '0;
                end else if (agree_q == AGR_LAST) begin
                    db_d    = sync_2[i];
                    agree_d = '0;
                end else begin
                    agree_d = agree_q + 1'b1;
                end
            end
        end

        assign db_rise = tick & ~db_q &  db_d;
        assign db_fall = tick &  db_q & ~db_d;

        // A release on the same tick as a terminal count wins and suppresses long/repeat.
        always_comb begin
            state_d  = state_q;
            hold_d   = hold_q;
            rep_d    = rep_q;
            press_ev = 1'b0;
            rel_ev   = 1'b0;
            long_ev  = 1'b0;
            rep_ev   = 1'b0;
            if (db_fall) begin
                state_d = ST_IDLE;
                hold_d  = '0;
                rep_d   = '0;
                rel_ev  = 1'b1;
            end else if (tick) begin
                case (state_q)
                    ST_IDLE: begin
                        if (db_rise) begin
                            state_d  = ST_PRESSED;
                            hold_d   = '0;
                            press_ev = 1'b1;
                        end
                    end
                    ST_PRESSED: begin
                        if (hold_q + 1'b1 == HLD_TERM) begin
                            state_d = ST_HELD;
                            hold_d  = HLD_TERM;
                            rep_d   = '0;
                            long_ev = 1'b1;
                        end else begin
                            hold_d = hold_q + 1'b1;
                        end
                    end
                    ST_HELD: begin
                        if (rep_q + 1'b1 == REP_TERM) begin
                            rep_d  = '0;
                            rep_ev = 1'b1;
                        end else begin
                            rep_d = rep_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        hold_d  = '0;
                        rep_d   = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge Clock_50 or negedge Resetn) begin
            if (!Resetn) begin
                state_q    <= ST_IDLE;
                db_q       <= 1'b0;
                agree_q    <= '0;
                hold_q     <= '0;
                rep_q      <= '0;
                pushed_q   <= 1'b0;
                released_q <= 1'b0;
                long_q     <= 1'b0;
            end else begin
                state_q    <= state_d;
                db_q       <= db_d;
                agree_q    <= agree_d;
                hold_q     <= hold_d;
                rep_q      <= rep_d;
                pushed_q   <= level_mode[i] ? db_d : (press_ev | (rep_ev & repeat_en));
                released_q <= rel_ev;
                long_q     <= long_ev;
            end
        end

        assign PB_pushed[i]   = pushed_q;
        assign PB_level[i]    = db_q;
        assign PB_released[i] = released_q;
        assign PB_long[i]     = long_q;
    end

endmodule

// File: tb/tb_pb_debounce_array.sv
// Bench for pb_debounce_array: directed scenarios plus random button activity,
// each cycle checked against a tick-counting behavioural model.
module tb_pb_debounce_array;

    localparam int NUM_PB       = 4;
    localparam int SAMPLE_DIV   = 4;
    localparam int DEBOUNCE_LEN = 3;
    localparam int HOLD_TICKS   = 5;
    localparam int REPEAT_TICKS = 2;

    logic              Clock_50 = 1'b0;
    logic              Resetn = 1'b0;
    logic [NUM_PB-1:0] PB_signal = '1;
    logic [NUM_PB-1:0] level_mode = '0;
    logic              repeat_en = 1'b0;
    logic [NUM_PB-1:0] PB_pushed;
    logic [NUM_PB-1:0] PB_level;
    logic [NUM_PB-1:0] PB_released;
    logic [NUM_PB-1:0] PB_long;

    pb_debounce_array #(
        .NUM_PB      (NUM_PB),
        .SAMPLE_DIV  (SAMPLE_DIV),
        .DEBOUNCE_LEN(DEBOUNCE_LEN),
        .HOLD_TICKS  (HOLD_TICKS),
        .REPEAT_TICKS(REPEAT_TICKS)
    ) dut (
        .Clock_50   (Clock_50),
        .Resetn     (Resetn),
        .PB_signal  (PB_signal),
        .level_mode (level_mode),
        .repeat_en  (repeat_en),
        .PB_pushed  (PB_pushed),
        .PB_level   (PB_level),
        .PB_released(PB_released),
        .PB_long    (PB_long)
    );

    always #5 Clock_50 = ~Clock_50;

    int vectors = 0;
    int miscompares = 0;

    // Model: raw history queue gives the two-cycle synchroniser delay; each channel keeps
    // its debounced state, the run of disagreeing samples and the ticks since the press.
    int                edge_cnt;
    logic [NUM_PB-1:0] hist[$];
    logic [NUM_PB-1:0] m_db;
    int                m_run[NUM_PB];
    int                m_t[NUM_PB];
    logic [NUM_PB-1:0] exp_pushed, exp_level, exp_released, exp_long;

    task automatic model_clear();
        edge_cnt = 0;
        hist = {};
        hist.push_back('0);
        hist.push_back('0);
        m_db = '0;
        for (int i = 0; i < NUM_PB; i++) begin
            m_run[i] = 0;
            m_t[i]   = 0;
        end
        exp_pushed   = '0;
        exp_level    = '0;
        exp_released = '0;
        exp_long     = '0;
    endtask

    task automatic model_step();
        logic [NUM_PB-1:0] smp;
        logic              pulse;
        if (!Resetn) begin
            model_clear();
            return;
        end
        edge_cnt++;
        smp = hist.pop_front();
        hist.push_back(~PB_signal);
        exp_pushed   = '0;
        exp_released = '0;
        exp_long     = '0;
        for (int i = 0; i < NUM_PB; i++) begin
            pulse = 1'b0;
            if (edge_cnt % SAMPLE_DIV == 0) begin
                if (smp[i] == m_db[i]) m_run[i] = 0;
                else m_run[i]++;
                if (m_run[i] == DEBOUNCE_LEN) begin
                    m_run[i] = 0;
                    m_db[i]  = smp[i];
                    if (m_db[i]) begin
                        pulse  = 1'b1;
                        m_t[i] = 0;
                    end else begin
                        exp_released[i] = 1'b1;
                    end
                end else if (m_db[i]) begin
                    m_t[i]++;
                    if (m_t[i] == HOLD_TICKS) exp_long[i] = 1'b1;
                    if (m_t[i] > HOLD_TICKS && (m_t[i] - HOLD_TICKS) % REPEAT_TICKS == 0 && repeat_en)
                        pulse = 1'b1;
                end
            end
            exp_level[i]  = m_db[i];
            exp_pushed[i] = level_mode[i] ? m_db[i] : pulse;
        end
    endtask

    // Advance one clock; returns 1 time unit after the edge, where outputs are sampled.
    task automatic cycle();
        @(posedge Clock_50);
        model_step();
        #1;
    endtask

    task automatic settle();
        PB_signal = '1;
        for (int c = 0; c < 8 * SAMPLE_DIV; c++) cycle();
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        model_clear();
        for (int c = 0; c < 3; c++) begin
            cycle();
            vectors++;
            if ({PB_pushed, PB_level, PB_released, PB_long} !== '0) begin
                miscompares++;
                $display("FAIL reset_state: got pushed=%b level=%b released=%b long=%b, want all 0",
                         PB_pushed, PB_level, PB_released, PB_long);
            end
        end
        Resetn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cycle();
            vectors++;
            if ({PB_pushed, PB_level, PB_released, PB_long} !== {exp_pushed, exp_level, exp_released, exp_long}) begin
                miscompares++;
                $display("FAIL reset_idle: got %b/%b/%b/%b want %b/%b/%b/%b", PB_pushed, PB_level, PB_released,
                         PB_long, exp_pushed, exp_level, exp_released, exp_long);
            end
        end
    endtask

    task automatic test_clean_press();
        int n_push = 0;
        int n_rel = 0;
        PB_signal = 4'b1110;
        for (int c = 0; c < 14 * SAMPLE_DIV; c++) begin
            if (c == 8 * SAMPLE_DIV) PB_signal = 4'b1111;
            cycle();
            n_push += int'(PB_pushed[0]);
            n_rel  += int'(PB_released[0]);
            vectors++;
            if ({PB_pushed, PB_level, PB_released, PB_long} !== {exp_pushed, exp_level, exp_released, exp_long}) begin
                miscompares++;
                $display("FAIL clean_press: got %b/%b/%b/%b want %b/%b/%b/%b", PB_pushed, PB_level, PB_released,
                         PB_long, exp_pushed, exp_level, exp_released, exp_long);
            end
        end
        vectors++;
        if (n_push != 1 || n_rel != 1) begin
            miscompares++;
            $display("FAIL clean_press_counts: got push=%0d rel=%0d, want 1 and 1", n_push, n_rel);
        end
    endtask

    task automatic test_bounce();
        int activity = 0;
        for (int r = 0; r < 4; r++) begin
            for (int ph = 0; ph < 3; ph++) begin
                PB_signal = (ph == 2) ? 4'b1111 : 4'b1101;
                for (int c = 0; c < SAMPLE_DIV; c++) begin
                    cycle();
                    activity += int'(|{PB_pushed, PB_level, PB_released, PB_long});
                    vectors++;
                    if ({PB_pushed, PB_level, PB_released, PB_long} !== {exp_pushed, exp_level, exp_released, exp_long}) begin
                        miscompares++;
                        $display("FAIL bounce: got %b/%b/%b/%b want %b/%b/%b/%b", PB_pushed, PB_level,
                                 PB_released, PB_long, exp_pushed, exp_level, exp_released, exp_long);
                    end
                end
            end
        end
        vectors++;
        if (activity != 0) begin
            miscompares++;
            $display("FAIL bounce_activity: got %0d active cycles, want 0", activity);
        end
    endtask

    task automatic test_long_repeat();
        int n_long = 0;
        int n_rel = 0;
        repeat_en = 1'b1;
        PB_signal = 4'b1011;
        for (int c = 0; c < 20 * SAMPLE_DIV; c++) begin
            if (c == 14 * SAMPLE_DIV) PB_signal = 4'b1111;
            cycle();
            n_long += int'(PB_long[2]);
            n_rel  += int'(PB_released[2]);
            vectors++;
            if ({PB_pushed, PB_level, PB_released, PB_long} !== {exp_pushed, exp_level, exp_released, exp_long}) begin
                miscompares++;
                $display("FAIL long_repeat: got %b/%b/%b/%b want %b/%b/%b/%b", PB_pushed, PB_level,
                         PB_released, PB_long, exp_pushed, exp_level, exp_released, exp_long);
            end
        end
        vectors++;
        if (n_long != 1 || n_rel != 1) begin
            miscompares++;
            $display("FAIL long_repeat_counts: got long=%0d rel=%0d, want 1 and 1", n_long, n_rel);
        end
        repeat_en = 1'b0;
    endtask

    task automatic test_level_mode();
        int   n_long = 0;
        int   n_rise = 0;
        logic prev = 1'b0;
        level_mode = 4'b1000;
        repeat_en  = 1'b1;
        PB_signal  = 4'b0111;
        for (int c = 0; c < 15 * SAMPLE_DIV; c++) begin
            if (c == 10 * SAMPLE_DIV) PB_signal = 4'b1111;
            cycle();
            n_long += int'(PB_long[3]);
            n_rise += int'(PB_pushed[3] & ~prev);
            prev = PB_pushed[3];
            vectors++;
            if (PB_pushed[3] !== PB_level[3]) begin
                miscompares++;
                $display("FAIL level_follow: got pushed=%b, want level=%b", PB_pushed[3], PB_level[3]);
            end
            vectors++;
            if ({PB_pushed, PB_level, PB_released, PB_long} !== {exp_pushed, exp_level, exp_released, exp_long}) begin
                miscompares++;
                $display("FAIL level_mode: got %b/%b/%b/%b want %b/%b/%b/%b", PB_pushed, PB_level,
                         PB_released, PB_long, exp_pushed, exp_level, exp_released, exp_long);
            end
        end
        vectors++;
        if (n_long != 1 || n_rise != 1) begin
            miscompares++;
            $display("FAIL level_counts: got long=%0d rises=%0d, want 1 and 1", n_long, n_rise);
        end
        level_mode = '0;
        repeat_en  = 1'b0;
    endtask

    task automatic test_simultaneous();
        int both = 0;
        PB_signal = 4'b0110;
        for (int c = 0; c < 6 * SAMPLE_DIV; c++) begin
            cycle();
            both += int'(PB_pushed[0] & PB_pushed[3]);
            vectors++;
            if ({PB_pushed, PB_level, PB_released, PB_long} !== {exp_pushed, exp_level, exp_released, exp_long}) begin
                miscompares++;
                $display("FAIL simultaneous: got %b/%b/%b/%b want %b/%b/%b/%b", PB_pushed, PB_level,
                         PB_released, PB_long, exp_pushed, exp_level, exp_released, exp_long);
            end
        end
        vectors++;
        if (both != 1) begin
            miscompares++;
            $display("FAIL simultaneous_pulse: got %0d joint pulses, want 1", both);
        end
    endtask

    task automatic test_reset_mid_hold();
        int first_push = -1;
        PB_signal = 4'b1110;
        for (int c = 0; c < 12 * SAMPLE_DIV; c++) cycle();
        vectors++;
        if (PB_level[0] !== 1'b1 || m_t[0] < HOLD_TICKS) begin
            miscompares++;
            $display("FAIL mid_hold_setup: got level=%b ticks=%0d, want level=1 ticks>=%0d",
                     PB_level[0], m_t[0], HOLD_TICKS);
        end
        Resetn = 1'b0;
        model_clear();
        #1;
        vectors++;
        if ({PB_pushed, PB_level, PB_released, PB_long} !== '0) begin
            miscompares++;
            $display("FAIL reset_async: got %b/%b/%b/%b, want all 0", PB_pushed, PB_level, PB_released, PB_long);
        end
        for (int c = 0; c < 2; c++) begin
            cycle();
            vectors++;
            if ({PB_pushed, PB_level, PB_released, PB_long} !== '0) begin
                miscompares++;
                $display("FAIL reset_hold: got %b/%b/%b/%b, want all 0", PB_pushed, PB_level, PB_released, PB_long);
            end
        end
        Resetn = 1'b1;
        for (int c = 1; c <= 5 * SAMPLE_DIV; c++) begin
            cycle();
            if (PB_pushed[0] && first_push < 0) first_push = c;
            vectors++;
            if ({PB_pushed, PB_level, PB_released, PB_long} !== {exp_pushed, exp_level, exp_released, exp_long}) begin
                miscompares++;
                $display("FAIL after_reset: got %b/%b/%b/%b want %b/%b/%b/%b", PB_pushed, PB_level,
                         PB_released, PB_long, exp_pushed, exp_level, exp_released, exp_long);
            end
        end
        vectors++;
        if (first_push != DEBOUNCE_LEN * SAMPLE_DIV) begin
            miscompares++;
            $display("FAIL fresh_press_latency: got cycle %0d, want cycle %0d", first_push, DEBOUNCE_LEN * SAMPLE_DIV);
        end
    endtask

    task automatic test_random();
        int dur[NUM_PB];
        for (int i = 0; i < NUM_PB; i++) dur[i] = 1;
        for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) begin
                level_mode = NUM_PB'($urandom_range(0, (1 << NUM_PB) - 1));
                repeat_en  = 1'($urandom_range(0, 1));
            end
            for (int i = 0; i < NUM_PB; i++) begin
                dur[i]--;
                if (dur[i] <= 0) begin
                    PB_signal[i] = ~PB_signal[i];
                    dur[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : int'($urandom_range(10, 90));
                end
            end
            cycle();
            vectors++;
            if ({PB_pushed, PB_level, PB_released, PB_long} !== {exp_pushed, exp_level, exp_released, exp_long}) begin
                miscompares++;
                $display("FAIL random cycle %0d: got %b/%b/%b/%b want %b/%b/%b/%b", c, PB_pushed, PB_level,
                         PB_released, PB_long, exp_pushed, exp_level, exp_released, exp_long);
            end
        end
        level_mode = '0;
        repeat_en  = 1'b0;
    endtask

    initial begin
        model_clear();
        #1;
        test_reset();
        test_clean_press();
        settle();
        test_bounce();
        settle();
        test_long_repeat();
        settle();
        test_level_mode();
        settle();
        test_simultaneous();
        settle();
        test_reset_mid_hold();
        settle();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
